// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes simple ALU requests (R-type, I-type ALU, NOP) into
//               RV32I instruction words and queues them in a 4-entry in-order
//               FIFO for a downstream fetch/IF consumer.
// Ports       : clk, reset_n         - clock, async active-low reset
//               flush                - synchronous clear of queued words
//               req_valid/req_ready  - request handshake
//               req_kind, req_funct3, req_funct7b5, req_rd, req_rs1,
//               req_rs2, req_imm     - request fields
//               out_valid/out_ready  - output handshake
//               out_instr            - FIFO head (NOP when empty)
//               fifo_level           - entries queued (0..4)
//               issued_count         - output handshakes, wraps at 16 bits
//               err_illegal          - sticky illegal-request flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [2:0]  req_funct3,
    input  logic        req_funct7b5,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [11:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [2:0]  fifo_level,
    output logic [15:0] issued_count,
    output logic        err_illegal
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [1:0]  KIND_R    = 2'b00;
    localparam logic [1:0]  KIND_I    = 2'b01;
    localparam logic [1:0]  KIND_NOP  = 2'b10;
    localparam int          DEPTH     = 4;

    logic [31:0] mem [DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  level;
    logic [15:0] count;
    logic        err;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        is_shift;
    logic [11:0] i_imm;
    logic        accept;
    logic        push;
    logic        pop;

    // Instruction encoder and legality check
    always_comb begin
        enc_word    = NOP_INSTR;
        enc_illegal = 1'b0;
        is_shift    = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
        // Shift-immediates carry only a 5-bit shamt; bit 30 selects SRAI.
        i_imm       = is_shift ? {1'b0, req_funct7b5, 5'b00000, req_imm[4:0]} : req_imm;
        case (req_kind)
            KIND_R: begin
                enc_illegal = req_funct7b5 && !((req_funct3 == 3'b000) || (req_funct3 == 3'b101));
                enc_word    = {1'b0, req_funct7b5, 5'b00000, req_rs2, req_rs1,
                               req_funct3, req_rd, OP_R};
            end
            KIND_I: begin
                enc_illegal = req_funct7b5 && (req_funct3 != 3'b101);
                enc_word    = {i_imm, req_rs1, req_funct3, req_rd, OP_I};
            end
            KIND_NOP: begin
                enc_word    = NOP_INSTR;
            end
            default: begin
                enc_illegal = 1'b1;
            end
        endcase
    end

    // Gating with reset_n keeps req_ready low while reset is held.
    assign req_ready = reset_n && (level < 3'd4) && !flush;
    assign accept    = req_valid && req_ready;
    assign push      = accept && !enc_illegal;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            level  <= 3'd0;
            count  <= 16'd0;
            err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_INSTR;
            end
        end else begin
            if (accept && enc_illegal) begin
                err <= 1'b1;
            end
            if (flush) begin
                // Flush wins over any push/pop; the counter and error flag keep their values.
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
                level  <= 3'd0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= enc_word;
                    wr_ptr      <= wr_ptr + 2'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 2'd1;
                    count  <= count + 16'd1;
                end
                case ({push, pop})
                    2'b10:   level <= level + 3'd1;
                    2'b01:   level <= level - 3'd1;
                    default: level <= level;
                endcase
            end
        end
    end

    assign out_valid    = (level != 3'd0);
    assign out_instr    = out_valid ? mem[rd_ptr] : NOP_INSTR;
    assign fifo_level   = level;
    assign issued_count = count;
    assign err_illegal  = err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_funct3;
    logic        req_funct7b5;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [11:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  fifo_level;
    logic [15:0] issued_count;
    logic        err_illegal;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_count;
    logic [31:0] exp_words [4];

    instr_encoder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .req_funct3   (req_funct3),
        .req_funct7b5 (req_funct7b5),
        .req_rd       (req_rd),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .fifo_level   (fifo_level),
        .issued_count (issued_count),
        .err_illegal  (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] kind, input logic [2:0] f3, input logic f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [11:0] imm);
        req_kind     = kind;
        req_funct3   = f3;
        req_funct7b5 = f7;
        req_rd       = rd;
        req_rs1      = rs1;
        req_rs2      = rs2;
        req_imm      = imm;
    endtask

    // Called at #1 after a rising edge; presents the request for one edge.
    task automatic push_req(input logic [1:0] kind, input logic [2:0] f3, input logic f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [11:0] imm);
        set_req(kind, f3, f7, rd, rs1, rs2, imm);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_count = exp_count + 16'd1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 16'd0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        out_ready = 1'b0;
        set_req(2'b00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);

        // Reset state
        #3;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0000_0013);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_count", {16'd0, issued_count}, 32'd0);
        check("rst_err", {31'd0, err_illegal}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // R-type ADD / SUB
        push_req(2'b00, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_instr", out_instr, 32'h0020_81B3);
        check("add_level", {29'd0, fifo_level}, 32'd1);
        pop_one();
        check("add_pop_level", {29'd0, fifo_level}, 32'd0);
        check("empty_instr", out_instr, 32'h0000_0013);
        check("add_pop_count", {16'd0, issued_count}, {16'd0, exp_count});
        push_req(2'b00, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 12'd0);
        check("sub_instr", out_instr, 32'h4020_81B3);
        pop_one();

        // I-type ADDI / SRAI / SLLI (upper imm bits ignored) / NOP
        push_req(2'b01, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 12'hFFF);
        check("addi_instr", out_instr, 32'hFFF0_0293);
        pop_one();
        push_req(2'b01, 3'b101, 1'b1, 5'd6, 5'd7, 5'd0, 12'h003);
        check("srai_instr", out_instr, 32'h4033_D313);
        pop_one();
        push_req(2'b01, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 12'hFE5);
        check("slli_instr", out_instr, 32'h0051_1093);
        pop_one();
        push_req(2'b10, 3'b111, 1'b1, 5'd31, 5'd31, 5'd31, 12'hABC);
        check("nop_instr", out_instr, 32'h0000_0013);
        check("nop_valid", {31'd0, out_valid}, 32'd1);
        pop_one();
        check("count_after_basic", {16'd0, issued_count}, {16'd0, exp_count});

        // Backpressure: 4 accepted, 5th refused
        exp_words[0] = 32'h0020_80B3;
        exp_words[1] = 32'h0020_8133;
        exp_words[2] = 32'h0020_81B3;
        exp_words[3] = 32'h0020_8233;
        for (int i = 0; i < 4; i++) begin
            push_req(2'b00, 3'b000, 1'b0, 5'(i + 1), 5'd1, 5'd2, 12'd0);
        end
        check("bp_level4", {29'd0, fifo_level}, 32'd4);
        check("bp_head", out_instr, exp_words[0]);
        set_req(2'b00, 3'b000, 1'b0, 5'd5, 5'd1, 5'd2, 12'd0);
        req_valid = 1'b1;
        #1;
        check("bp_ready_full", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_level_hold", {29'd0, fifo_level}, 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_word%0d", i), out_instr, exp_words[i]);
            @(posedge clk);
            #1;
            exp_count = exp_count + 16'd1;
        end
        out_ready = 1'b0;
        check("bp_drained", {29'd0, fifo_level}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_count", {16'd0, issued_count}, {16'd0, exp_count});

        // Illegal requests: accepted, not queued, sticky error
        push_req(2'b11, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0);
        check("ill_kind_level", {29'd0, fifo_level}, 32'd0);
        check("ill_kind_err", {31'd0, err_illegal}, 32'd1);
        push_req(2'b01, 3'b000, 1'b1, 5'd1, 5'd1, 5'd0, 12'd1);
        check("ill_i_level", {29'd0, fifo_level}, 32'd0);
        push_req(2'b00, 3'b001, 1'b1, 5'd1, 5'd1, 5'd1, 12'd0);
        check("ill_r_level", {29'd0, fifo_level}, 32'd0);
        push_req(2'b00, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        check("ill_sticky", {31'd0, err_illegal}, 32'd1);
        check("legal_after_ill", out_instr, 32'h0020_81B3);

        // Simultaneous push and pop keeps level and order
        set_req(2'b00, 3'b000, 1'b0, 5'd1, 5'd1, 5'd2, 12'd0);
        req_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        out_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check("pp_level", {29'd0, fifo_level}, 32'd1);
        check("pp_head", out_instr, 32'h0020_80B3);
        pop_one();

        // Flush with 3 queued and a concurrent valid request and pop
        for (int i = 0; i < 3; i++) begin
            push_req(2'b00, 3'b000, 1'b0, 5'(i + 1), 5'd1, 5'd2, 12'd0);
        end
        check("fl_pre_level", {29'd0, fifo_level}, 32'd3);
        set_req(2'b00, 3'b000, 1'b0, 5'd4, 5'd1, 5'd2, 12'd0);
        req_valid = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check("fl_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        out_ready = 1'b0;
        check("fl_level", {29'd0, fifo_level}, 32'd0);
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_count", {16'd0, issued_count}, {16'd0, exp_count});
        check("fl_err", {31'd0, err_illegal}, 32'd1);

        // Counter wrap: stream push+pop up to 16'hFFFF with 3 queued
        for (int i = 0; i < 3; i++) begin
            push_req(2'b10, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
        end
        begin
            int k;
            k = 32'hFFFF - int'(exp_count);
            set_req(2'b10, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
            req_valid = 1'b1;
            out_ready = 1'b1;
            repeat (k) @(posedge clk);
            #1;
            req_valid = 1'b0;
            out_ready = 1'b0;
            exp_count = 16'hFFFF;
        end
        check("wrap_pre_count", {16'd0, issued_count}, 32'h0000_FFFF);
        check("wrap_pre_level", {29'd0, fifo_level}, 32'd3);
        req_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        out_ready = 1'b0;
        check("wrap_count", {16'd0, issued_count}, 32'd0);
        check("wrap_level", {29'd0, fifo_level}, 32'd3);
        pop_one();
        check("post_wrap_count", {16'd0, issued_count}, 32'd1);
        check("post_wrap_level", {29'd0, fifo_level}, 32'd2);

        // Asynchronous reset mid-cycle with entries queued
        req_valid = 1'b1;
        out_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_req_ready", {31'd0, req_ready}, 32'd0);
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_out_instr", out_instr, 32'h0000_0013);
        check("ar_level", {29'd0, fifo_level}, 32'd0);
        check("ar_count", {16'd0, issued_count}, 32'd0);
        check("ar_err", {31'd0, err_illegal}, 32'd0);
        req_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ar_rel_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("ar_rel_level", {29'd0, fifo_level}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports, one per line, in this order (clock and reset first):
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  reset, asynchronous assert, active-low
- flush  input  1  synchronous clear of queued instructions
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_kind  input  2  00 R-type, 01 I-type ALU, 10 NOP, 11 reserved
- req_funct3  input  3  funct3 field
- req_funct7b5  input  1  funct7 bit 5 (SUB/SRA/SRAI select)
- req_rd, req_rs1, req_rs2  input  5 each  register indices
- req_imm  input  12  I-type immediate
- out_valid  output  1  out_instr holds a valid instruction
- out_ready  input  1  consumer (fetch/IF stage) takes word when out_valid && out_ready
- out_instr  output  32  encoded RV32I instruction word
- fifo_level  output  3  entries queued, 0..4
- issued_count  output  16  instructions handed out
- err_illegal  output  1  sticky illegal-request flag
REQ-002 SHALL use one clock domain; reset is asynchronous and active-low.

Function
REQ-003 SHALL encode R-type as {0,funct7b5,00000, rs2, rs1, funct3, rd, 0110011}.
REQ-004 SHALL encode I-type as {imm[11:0], rs1, funct3, rd, 0010011}; for funct3 001/101, imm[11:5] SHALL be {0,funct7b5,00000} and imm[4:0] SHALL be req_imm[4:0].
REQ-005 SHALL encode NOP as 32'h00000013, ignoring all field inputs.
REQ-006 SHALL treat as illegal: kind 11; R-type with funct7b5=1 and funct3 not 000/101; I-type with funct7b5=1 and funct3 not 101.
REQ-007 Illegal requests SHALL be accepted (handshake completes), not enqueued, and SHALL set err_illegal, which stays 1 until reset.
REQ-008 SHALL buffer encoded words in a 4-entry in-order FIFO; req_ready = (fifo_level < 4) && !flush.
REQ-009 out_valid SHALL equal (fifo_level != 0); out_instr SHALL be the FIFO head, registered, stable while out_valid && !out_ready.
REQ-010 Latency: a legal request accepted in cycle N into an empty FIFO SHALL appear on out_instr with out_valid=1 in cycle N+1.
REQ-011 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve order; at level 4 no push occurs (req_ready=0), pop alone decrements.
REQ-012 Pointers SHALL wrap modulo 4; fifo_level SHALL never exceed 4 or underflow.
REQ-013 flush SHALL, at the next edge, empty the FIFO (level 0, out_valid 0) and override any push or pop in that cycle; issued_count and err_illegal SHALL be unaffected.
REQ-014 issued_count SHALL increment by 1 on each out handshake, wrap 16'hFFFF -> 16'h0000, and clear only on reset.
REQ-015 out_instr SHALL read 32'h00000013 whenever out_valid=0.

Reset
REQ-016 While reset_n=0, outputs SHALL be: req_ready 0, out_valid 0, out_instr 32'h00000013, fifo_level 0, issued_count 0, err_illegal 0; queued entries SHALL be discarded.
REQ-017 Reset asserted mid-transfer SHALL take effect immediately (asynchronously); req_ready SHALL rise in the first cycle after reset_n deasserts.

Verification
REQ-018 R-type: kind 00, f3 000, f7b5 0, rd 3, rs1 1, rs2 2 -> out_instr 32'h002081B3 next cycle; same with f7b5 1 -> 32'h402081B3.
REQ-019 I-type: kind 01, f3 000, rd 5, rs1 0, imm 12'hFFF -> 32'hFFF00293; kind 01, f3 101, f7b5 1, rd 6, rs1 7, imm 3 -> 32'h4033D313.
REQ-020 Backpressure: out_ready=0, push 5 legal requests -> 4 accepted, req_ready=0 on 5th, fifo_level 4; release out_ready -> 4 words in order, issued_count 4.
REQ-021 Illegal: kind 11 then kind 01 f3 000 f7b5 1 -> both accepted, fifo_level stays 0, err_illegal 1 and sticky.
REQ-022 Flush with 3 queued and a concurrent valid request -> next cycle fifo_level 0, out_valid 0, request not enqueued, issued_count unchanged.
REQ-023 Reset mid-operation with 2 queued and issued_count 16'hFFFF -> all outputs at REQ-016 values; separately, one more handshake from 16'hFFFF wraps to 0.
